writeback_forward_unit: RTL

- Pipeline-side counterpart of the register file. It produces the register file's write-port stimulus (RW, PW, EN) from the EX/MEM/WB destination pipeline.
- It also consumes the register file's read-port outputs (PA, PB) and overrides them with in-flight results (forwarding).
- It detects load-use hazards and raises STALL to the hazard/PC logic. Sits between ID/EX control and the register file.

---
 rtl/writeback_forward_unit.sv | 73 +++++++
 1 files changed

// File: rtl/writeback_forward_unit.sv
// writeback_forward_unit: EX/MEM/WB destination pipeline driving regfile writes, operand forwarding and load-use stall
module writeback_forward_unit #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] ID_RA,
  input  logic [AW-1:0] ID_RB,
  input  logic          ID_USE_A,
  input  logic          ID_USE_B,
  input  logic          ID_LE,
  input  logic [AW-1:0] ID_RW,
  input  logic          ID_LOAD,
  input  logic [DW-1:0] EX_RESULT,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic [DW-1:0] PA_IN,
  input  logic [DW-1:0] PB_IN,
  output logic          STALL,
  output logic [1:0]    SEL_A,
  output logic [1:0]    SEL_B,
  output logic [DW-1:0] OPA,
  output logic [DW-1:0] OPB,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] PW,
  output logic          EN
);
  logic          ex_le, ex_load, mem_le, mem_load, wb_le;
  logic [AW-1:0] ex_rw, mem_rw, wb_rw;
  logic [DW-1:0] mem_alu, wb_pw, mem_val;
  assign mem_val = mem_load ? MEM_RDATA : mem_alu;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_le    <= 1'b0;
      ex_load  <= 1'b0;
      ex_rw    <= '0;
      mem_le   <= 1'b0;
      mem_load <= 1'b0;
      mem_rw   <= '0;
      mem_alu  <= '0;
      wb_le    <= 1'b0;
      wb_rw    <= '0;
      wb_pw    <= '0;
    end else begin
      ex_le    <= ID_LE & ~STALL;
      ex_load  <= ID_LOAD & ~STALL;
      ex_rw    <= STALL ? '0 : ID_RW;
      mem_le   <= ex_le;
      mem_load <= ex_load;
      mem_rw   <= ex_rw;
      mem_alu  <= EX_RESULT;
      wb_le    <= mem_le;
      wb_rw    <= mem_rw;
      wb_pw    <= mem_val;
    end
  end
  assign STALL = ex_le & ex_load & (|ex_rw) &
                 ((ID_USE_A & (ID_RA == ex_rw)) | (ID_USE_B & (ID_RB == ex_rw)));
  // a load in EX never forwards; that case always raises STALL instead
  assign SEL_A = (!ID_USE_A || ID_RA == '0 || STALL) ? 2'd0 :
                 (ex_le && !ex_load && ex_rw == ID_RA) ? 2'd1 :
                 (mem_le && mem_rw == ID_RA) ? 2'd2 :
                 (wb_le && wb_rw == ID_RA) ? 2'd3 : 2'd0;
  assign SEL_B = (!ID_USE_B || ID_RB == '0 || STALL) ? 2'd0 :
                 (ex_le && !ex_load && ex_rw == ID_RB) ? 2'd1 :
                 (mem_le && mem_rw == ID_RB) ? 2'd2 :
                 (wb_le && wb_rw == ID_RB) ? 2'd3 : 2'd0;
  assign OPA = SEL_A == 2'd1 ? EX_RESULT : SEL_A == 2'd2 ? mem_val : SEL_A == 2'd3 ? wb_pw : PA_IN;
  assign OPB = SEL_B == 2'd1 ? EX_RESULT : SEL_B == 2'd2 ? mem_val : SEL_B == 2'd3 ? wb_pw : PB_IN;
  assign RW  = wb_rw;
  assign PW  = wb_pw;
  assign EN  = wb_le & (|wb_rw);
endmodule
